// File: rtl/axi_imem_rd_model_pkg.sv
// Shared AXI read-model types: burst kinds, response codes and the burst header
// carried by every queued read command.
package axi_mem_pkg;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'd0,
    BURST_INCR  = 2'd1,
    BURST_WRAP  = 2'd2,
    BURST_RSVD  = 2'd3
  } burst_e;

  typedef enum logic [1:0] {
    RESP_OKAY   = 2'd0,
    RESP_EXOKAY = 2'd1,
    RESP_SLVERR = 2'd2,
    RESP_DECERR = 2'd3
  } resp_e;

  typedef struct packed {
    logic [7:0] len;
    burst_e     burst;
  } burst_hdr_t;

  // Reserved burst type, or a WRAP whose beat count is not 2/4/8/16.
  function automatic logic burst_illegal(burst_e burst, logic [7:0] len);
    return (burst == BURST_RSVD) ||
           ((burst == BURST_WRAP) &&
            !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15)));
  endfunction

endpackage

// File: rtl/axi_imem_rd_model_if.sv
// AXI4 read-address and read-data channels of the instruction-memory model.
interface axi_imem_rd_model_if #(
  parameter int ID_WIDTH   = 8,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic [ID_WIDTH-1:0]   arid;
  logic [ADDR_WIDTH-1:0] araddr;
  logic [7:0]            arlen;
  logic [1:0]            arburst;
  logic                  arvalid;
  logic                  arready;
  logic [ID_WIDTH-1:0]   rid;
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rlast;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output arid, araddr, arlen, arburst, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );

  modport slave (
    input  arid, araddr, arlen, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_imem_rd_model_delay_queue.sv
// Circular FIFO of accepted read bursts; every slot counts its start delay down
// in parallel so latencies of queued bursts overlap.
module axi_rd_delay_queue #(
  parameter int  DEPTH       = 4,
  parameter int  DELAY_WIDTH = 6,
  parameter type entry_t     = logic [7:0],
  parameter int  CW          = $clog2(DEPTH + 1)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push,
  input  entry_t                 push_entry,
  input  logic [DELAY_WIDTH-1:0] push_delay,
  input  logic                   pop,
  output entry_t                 head_entry,
  output logic                   head_eligible,
  output entry_t                 next_entry,
  output logic                   next_eligible,
  output logic                   full,
  output logic [CW-1:0]          count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  entry_t                 ent_q [DEPTH];
  logic [DELAY_WIDTH-1:0] dly_q [DEPTH];
  logic [PW-1:0]          rd_ptr, wr_ptr, nx_ptr;

  function automatic logic [PW-1:0] ptr_inc(logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge clock) begin
    for (int i = 0; i < DEPTH; i++)
      if (dly_q[i] != '0) dly_q[i] <= dly_q[i] - 1'b1;
    if (push) begin
      ent_q[wr_ptr] <= push_entry;
      dly_q[wr_ptr] <= push_delay;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Eligible means the delay reaches zero at the edge that would load the beat.
  assign nx_ptr        = ptr_inc(rd_ptr);
  assign head_entry    = ent_q[rd_ptr];
  assign next_entry    = ent_q[nx_ptr];
  assign head_eligible = (count != '0) && (dly_q[rd_ptr] <= DELAY_WIDTH'(1));
  assign next_eligible = (int'(count) > 1) && (dly_q[nx_ptr] <= DELAY_WIDTH'(1));
  assign full          = (int'(count) == DEPTH);

endmodule

// File: rtl/axi_imem_rd_model.sv
// Read-only AXI4 slave memory with per-burst start latency, several outstanding
// bursts, FIXED/INCR/WRAP addressing, error responses and a backdoor load port.
module axi_imem_rd_model
  import axi_mem_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 32,
  parameter int ID_WIDTH        = 8,
  parameter int MEM_WORDS       = 65536,
  parameter int MAX_OUTSTANDING = 4,
  parameter int DELAY_WIDTH     = 6
) (
  input  logic                         clock,
  input  logic                         reset,
  axi_imem_rd_model_if.slave           s_axi,
  input  logic [DELAY_WIDTH-1:0]       added_delay,
  input  logic                         load_en,
  input  logic [$clog2(MEM_WORDS)-1:0] load_addr,
  input  logic [DATA_WIDTH-1:0]        load_data
);
  localparam int OFFS = $clog2(DATA_WIDTH / 8);
  localparam int MW   = $clog2(MEM_WORDS);
  localparam int WW   = ADDR_WIDTH - OFFS;
  localparam int CW   = $clog2(MAX_OUTSTANDING + 1);

  typedef struct packed {
    logic [ID_WIDTH-1:0] id;
    logic [WW-1:0]       word;
    burst_hdr_t          hdr;
  } rd_entry_t;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  rd_entry_t             push_entry, head_entry, next_entry, src;
  logic                  push, pop, q_full, head_elig, next_elig;
  logic [CW-1:0]         q_count;
  logic                  sel_next, bypass, src_elig, advance, src_slverr, src_decerr;
  logic [7:0]            src_beat, beat_p1;
  logic [WW-1:0]         src_word;
  logic                  vld_p1, rlast_p1;
  logic [ID_WIDTH-1:0]   rid_p1;
  logic [DATA_WIDTH-1:0] rdata_p1;
  logic [1:0]            rresp_p1;

  function automatic logic [WW-1:0] beat_word(logic [WW-1:0] base, burst_hdr_t hdr,
                                              logic [7:0] beat);
    logic [WW-1:0] mask, step;
    mask = WW'(hdr.len);
    step = WW'(beat);
    case (hdr.burst)
      BURST_FIXED: beat_word = base;
      BURST_WRAP:  beat_word = (base & ~mask) | ((base + step) & mask);
      default:     beat_word = base + step;
    endcase
  endfunction

  always_ff @(posedge clock) begin
    if (load_en) mem[load_addr] <= load_data;
  end

  assign s_axi.arready = !reset && !q_full;
  assign push          = s_axi.arvalid && s_axi.arready;
  assign push_entry    = '{id:   s_axi.arid,
                           word: s_axi.araddr[ADDR_WIDTH-1:OFFS],
                           hdr:  '{len: s_axi.arlen, burst: burst_e'(s_axi.arburst)}};

  axi_rd_delay_queue #(
    .DEPTH       (MAX_OUTSTANDING),
    .DELAY_WIDTH (DELAY_WIDTH),
    .entry_t     (rd_entry_t),
    .CW          (CW)
  ) u_queue (
    .clock         (clock),
    .reset         (reset),
    .push          (push),
    .push_entry    (push_entry),
    .push_delay    (added_delay),
    .pop           (pop),
    .head_entry    (head_entry),
    .head_eligible (head_elig),
    .next_entry    (next_entry),
    .next_eligible (next_elig),
    .full          (q_full),
    .count         (q_count)
  );

  // Once the final beat of the head sits in the R stage the next beat comes
  // from the following burst; a zero-delay burst with nothing ahead of it
  // bypasses the queue so it answers the cycle after acceptance.
  always_comb begin
    sel_next   = vld_p1 && rlast_p1;
    bypass     = (sel_next ? (int'(q_count) < 2) : (q_count == '0)) &&
                 push && (added_delay == '0);
    src        = sel_next ? next_entry : head_entry;
    src_elig   = sel_next ? next_elig : head_elig;
    if (bypass) begin
      src      = push_entry;
      src_elig = 1'b1;
    end
    src_beat   = (vld_p1 && !rlast_p1) ? beat_p1 + 8'd1 : 8'd0;
    src_word   = beat_word(src.word, src.hdr, src_beat);
    src_slverr = burst_illegal(src.hdr.burst, src.hdr.len);
    src_decerr = (src_word >> MW) != '0;
    advance    = !vld_p1 || s_axi.rready;
  end

  assign pop = vld_p1 && rlast_p1 && s_axi.rready;

  // R stage (p1): holds one beat until the handshake.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      vld_p1   <= 1'b0;
      rlast_p1 <= 1'b0;
      rid_p1   <= '0;
      rdata_p1 <= '0;
      rresp_p1 <= RESP_OKAY;
      beat_p1  <= '0;
    end else if (advance) begin
      vld_p1 <= src_elig;
      if (src_elig) begin
        rid_p1   <= src.id;
        beat_p1  <= src_beat;
        rlast_p1 <= (src_beat == src.hdr.len);
        rdata_p1 <= (src_slverr || src_decerr) ? '0 : mem[src_word[MW-1:0]];
        rresp_p1 <= src_slverr ? RESP_SLVERR : (src_decerr ? RESP_DECERR : RESP_OKAY);
      end else begin
        rlast_p1 <= 1'b0;
      end
    end
  end

  assign s_axi.rvalid = vld_p1;
  assign s_axi.rlast  = rlast_p1;
  assign s_axi.rid    = rid_p1;
  assign s_axi.rdata  = rdata_p1;
  assign s_axi.rresp  = rresp_p1;

endmodule

// File: tb/tb_axi_imem_rd_model.sv
// Directed bench for axi_imem_rd_model: scoreboard of expected R beats built
// from an independent burst-address model and a shadow copy of preloaded data.
module tb_axi_imem_rd_model;
  localparam int DW = 32, AW = 32, IW = 8, MWD = 65536, MO = 4, DLW = 6;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic [DLW-1:0] added_delay = '0;
  logic           load_en     = 1'b0;
  logic [15:0]    load_addr   = '0;
  logic [31:0]    load_data   = '0;

  axi_imem_rd_model_if #(.ID_WIDTH(IW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s_axi ();

  axi_imem_rd_model #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW), .MEM_WORDS(MWD),
    .MAX_OUTSTANDING(MO), .DELAY_WIDTH(DLW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .s_axi       (s_axi),
    .added_delay (added_delay),
    .load_en     (load_en),
    .load_addr   (load_addr),
    .load_data   (load_data)
  );

  typedef struct {
    logic [7:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } exp_t;

  exp_t        sb [$];
  logic [31:0] shadow [int];
  int n_cmp = 0, n_bad = 0;
  int cyc = 0, rise_cyc = -1, last_hs = -1, hs_cnt = 0;
  logic        prev_rv = 1'b0, hold_pend = 1'b0, h_last;
  logic [7:0]  h_id;
  logic [31:0] h_data;
  logic [1:0]  h_resp;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected beats: byte-address model of FIXED/INCR/WRAP with error rules.
  task automatic model_burst(input logic [7:0] id, input longint addr, input int len,
                             input int burst);
    longint wsize, start, a;
    exp_t e;
    for (int i = 0; i <= len; i++) begin
      e.id   = id;
      e.last = (i == len);
      if (burst == 3 || (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15))) begin
        e.resp = 2'd2; e.data = '0;
      end else begin
        if (burst == 0) a = addr;
        else if (burst == 1) a = addr + 4 * i;
        else begin
          wsize = (len + 1) * 4;
          start = (addr / wsize) * wsize;
          a = start + ((addr - start + 4 * i) % wsize);
        end
        if (a >= longint'(MWD) * 4) begin e.resp = 2'd3; e.data = '0; end
        else begin e.resp = 2'd0; e.data = shadow[int'(a / 4)]; end
      end
      sb.push_back(e);
    end
  endtask

  task automatic preload(input int idx, input logic [31:0] d);
    @(posedge clock); #1;
    load_en = 1'b1; load_addr = 16'(idx); load_data = d;
    shadow[idx] = d;
    @(posedge clock); #1;
    load_en = 1'b0;
  endtask

  task automatic ar(input logic [7:0] id, input logic [31:0] addr, input logic [7:0] len,
                    input logic [1:0] burst, output int acc);
    s_axi.arid = id; s_axi.araddr = addr; s_axi.arlen = len; s_axi.arburst = burst;
    s_axi.arvalid = 1'b1;
    acc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (s_axi.arready) begin acc = cyc; break; end
    end
    if (acc < 0) check("ar_accept", s_axi.arready, 1);
    else model_burst(id, addr, len, burst);
    @(posedge clock); #1;
    s_axi.arvalid = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    for (int i = 0; i < bound; i++) begin
      @(posedge clock); #1;
      if (sb.size() == 0) break;
    end
    check("drain", sb.size(), 0);
  endtask

  // R-channel monitor, sampled on the falling edge.
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      prev_rv = 1'b0; hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        check("hold_rvalid", s_axi.rvalid, 1);
        check("hold_rid", s_axi.rid, h_id);
        check("hold_rdata", s_axi.rdata, h_data);
        check("hold_rresp", s_axi.rresp, h_resp);
        check("hold_rlast", s_axi.rlast, h_last);
      end
      if (s_axi.rvalid && s_axi.rready) begin
        check("sb_nonempty", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("rid", s_axi.rid, e.id);
          check("rdata", s_axi.rdata, e.data);
          check("rresp", s_axi.rresp, e.resp);
          check("rlast", s_axi.rlast, e.last);
        end
        hs_cnt++;
        last_hs = cyc;
      end
      if (s_axi.rvalid && !prev_rv) rise_cyc = cyc;
      prev_rv   = s_axi.rvalid;
      hold_pend = s_axi.rvalid && !s_axi.rready;
      h_id = s_axi.rid; h_data = s_axi.rdata; h_resp = s_axi.rresp; h_last = s_axi.rlast;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

  initial begin
    int acc, a1, a2, a3, a4, a5, start;
    s_axi.arvalid = 1'b0; s_axi.arid = '0; s_axi.araddr = '0;
    s_axi.arlen = '0; s_axi.arburst = '0; s_axi.rready = 1'b0;

    repeat (3) @(posedge clock);
    #1;
    check("rst_arready", s_axi.arready, 0);
    check("rst_rvalid", s_axi.rvalid, 0);
    check("rst_rlast", s_axi.rlast, 0);
    check("rst_rid", s_axi.rid, 0);
    check("rst_rdata", s_axi.rdata, 0);
    check("rst_rresp", s_axi.rresp, 0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) preload(i, 32'h11 * (i + 1));
    preload(MWD - 1, 32'hDEADBEEF);
    s_axi.rready = 1'b1;

    // Zero-delay 4-beat INCR
    added_delay = '0;
    ar(8'd5, 32'h0, 8'd3, 2'd1, acc);
    wait_drain(50);
    check("t1_first_rvalid_cyc", rise_cyc, acc + 1);
    check("t1_last_beat_cyc", last_hs, acc + 4);

    // Four overlapped delayed bursts fill the queue; fifth waits for a pop
    added_delay = 6'd10;
    ar(8'd1, 32'h0, 8'd0, 2'd1, a1);
    ar(8'd2, 32'h4, 8'd0, 2'd1, a2);
    ar(8'd3, 32'h8, 8'd0, 2'd1, a3);
    ar(8'd4, 32'hC, 8'd0, 2'd1, a4);
    check("t2_arready_full", s_axi.arready, 0);
    check("t2_accept_spacing", a4, a1 + 3);
    added_delay = '0;
    ar(8'd6, 32'h10, 8'd0, 2'd1, a5);
    check("t2_first_rvalid_cyc", rise_cyc, a1 + 11);
    check("t2_fifth_accept_cyc", a5, a1 + 12);
    wait_drain(50);
    check("t2_last_beat_cyc", last_hs, a1 + 15);

    // WRAP legal and illegal
    ar(8'd7, 32'h18, 8'd3, 2'd2, acc);
    wait_drain(50);
    ar(8'd8, 32'h0, 8'd2, 2'd2, acc);
    wait_drain(50);

    // Backpressure: rready toggles every cycle over an 8-beat burst
    start = hs_cnt;
    ar(8'd9, 32'h0, 8'd7, 2'd1, acc);
    for (int i = 0; i < 100 && sb.size() != 0; i++) begin
      @(posedge clock); #1;
      s_axi.rready = ~s_axi.rready;
    end
    s_axi.rready = 1'b1;
    check("t4_drain", sb.size(), 0);
    check("t4_beat_count", hs_cnt - start, 8);

    // Top-of-memory crossing and reserved burst type
    ar(8'd10, 32'h3FFFC, 8'd1, 2'd1, acc);
    wait_drain(50);
    ar(8'd11, 32'h40, 8'd0, 2'd3, acc);
    wait_drain(50);

    // Reset while beat 2 of a 4-beat burst is presented
    ar(8'd12, 32'h0, 8'd3, 2'd1, acc);
    repeat (2) @(posedge clock);
    #1;
    check("t6_mid_rvalid", s_axi.rvalid, 1);
    check("t6_mid_rdata", s_axi.rdata, shadow[2]);
    reset = 1'b1;
    sb.delete();
    #1;
    check("t6_rst_rvalid", s_axi.rvalid, 0);
    check("t6_rst_rlast", s_axi.rlast, 0);
    check("t6_rst_arready", s_axi.arready, 0);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    #1;
    check("t6_post_arready", s_axi.arready, 1);
    start = hs_cnt;
    ar(8'd13, 32'h0, 8'd3, 2'd1, acc);
    wait_drain(50);
    check("t6_post_beats", hs_cnt - start, 4);
    check("t6_post_rvalid_cyc", rise_cyc, acc + 1);

    repeat (3) @(posedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_imem_rd_model.md
Name:
axi_imem_rd_model

Overview:
Parametrised, read-only AXI4 slave memory model with programmable per-burst read latency and multiple outstanding bursts. Next-generation backing store behind the L1 instruction cache in the instruction-memory test harness. Adds INCR/WRAP/FIXED bursts, a configurable outstanding depth, error responses and a backdoor preload port. The harness ties off the instruction cache's write channels.

Parameters:
DATA_WIDTH, 32, R beat width in bits; power of two, ≥32.
ADDR_WIDTH, 32, AXI byte address width.
ID_WIDTH, 8, AXI ID width.
MEM_WORDS, 65536, memory depth in DATA_WIDTH words; power of two.
MAX_OUTSTANDING, 4, accepted-but-incomplete read bursts; power of two, ≥1.
DELAY_WIDTH, 6, width of added_delay.

Ports:
clock  in  1  sole clock, rising edge
reset  in  1  asynchronous, active-high reset
s_axi_arid  in  ID_WIDTH  burst ID
s_axi_araddr  in  ADDR_WIDTH  start byte address
s_axi_arlen  in  8  beats minus one
s_axi_arburst  in  2  burst type: 0 FIXED, 1 INCR, 2 WRAP, 3 reserved
s_axi_arvalid  in  1  AR valid
s_axi_arready  out  1  AR ready
s_axi_rid  out  ID_WIDTH  echoed ID
s_axi_rdata  out  DATA_WIDTH  read beat
s_axi_rresp  out  2  0 OKAY, 2 SLVERR, 3 DECERR
s_axi_rlast  out  1  final beat of burst
s_axi_rvalid  out  1  R valid
s_axi_rready  in  1  R ready
added_delay  in  DELAY_WIDTH  extra cycles before the first beat of each burst
load_en  in  1  backdoor write enable
load_addr  in  log2(MEM_WORDS)  backdoor word index
load_data  in  DATA_WIDTH  backdoor write data

Behaviour:
- Reset (async assert, sync release):
  - Outputs: arready=0, rvalid=0, rlast=0, rid=0, rdata=0, rresp=0.
  - Queue is emptied and count=0.
  - Memory array is not reset; preloaded contents survive reset.
- AR channel:
  - arready = (count < MAX_OUTSTANDING), decoded from registered count; no combinational dependence on arvalid or rready.
  - When full, a same-cycle pop does not enable acceptance.
  - On arvalid&&arready, push entry {id, addr, len, burst, delay=added_delay}.
  - added_delay is sampled only at acceptance; later changes affect only later bursts.
- Delay:
  - Every queued entry's delay field decrements by 1 each cycle while nonzero (saturates at 0), including non-head entries, so latencies overlap.
  - The head entry becomes eligible when its delay is 0.
  - Minimum latency: the first rvalid is asserted the cycle after AR acceptance when added_delay=0. With added_delay=D, first rvalid is asserted at acceptance+1+D.
- R output stage:
  - Registered; loaded when the stage is empty, or on rvalid&&rready, if the head is eligible.
  - Back-to-back beats across bursts with zero bubbles.
  - rvalid and all R fields are held stable until the handshake.
  - Responses return in acceptance order; IDs are not reordered.
- Beat generation:
  - Beat counter runs 0..len; rlast=(beat==len).
  - Head entry pops on the rlast handshake.
  - Word index = addr >> log2(DATA_WIDTH/8); unaligned low bits are ignored.
  - FIXED: same address every beat.
  - INCR: +DATA_WIDTH/8 per beat, no 4KB check.
  - WRAP: len must be 1, 3, 7 or 15; wraps within an aligned (len+1)*bytes window.
- Errors (every beat gets the error response, rdata=0, burst length still honoured):
  - Any beat address ≥ MEM_WORDS*bytes → DECERR.
  - burst=3, or WRAP with an illegal len → SLVERR.
- Backdoor: load_en writes mem[load_addr] at the clock edge. A beat loaded into the R stage in the same cycle sees the old data.
- Reset mid-burst: queued and in-flight bursts are discarded with no partial completion.

Decomposition:
- Package axi_mem_pkg holds the burst-type enum, response codes, and the queue-entry struct typedef.
- One sub-module, axi_rd_delay_queue: circular FIFO of MAX_OUTSTANDING entries with per-entry delay countdown, head-eligible flag, full/count outputs, and wrap-around pointers.

Test Plan:
- Preload mem[0..3]=0x11,0x22,0x33,0x44; added_delay=0; AR addr=0, len=3, INCR, id=5, rready=1 → first rvalid at accept+1; data 0x11..0x44 on 4 consecutive cycles; rid=5; rresp=0; rlast only on 0x44.
- added_delay=10; issue 4 single-beat bursts on consecutive cycles → arready drops after the 4th; first rvalid at first accept+11; remaining beats on following cycles (overlapped delays); 5th AR accepted only after a pop.
- WRAP, addr=0x18, len=3 → words 6,7,4,5; WRAP len=2 → 3 beats, all SLVERR, rdata=0.
- rready toggled 1/0 every cycle during an 8-beat INCR → no beat lost or duplicated; R fields stable while stalled.
- araddr=MEM_WORDS*4-4, len=1 → beat0 OKAY, beat1 DECERR with rlast; burst=3 → SLVERR.
- Assert reset during beat 2 of a 4-beat burst → rvalid=0 immediately; after release arready=1, count=0, and a new burst returns the preloaded data intact.
